esfa_alloc_sequencer: RTL
=========================

// Module: esfa_alloc_sequencer
// PURPOSE
//   Sequences allocation of a new array handle onto the ESFA cell bank.
//   On each request: broadcasts MARK_AVAIL to all cells, captures their per-cell
//   "free" results (resultBool = !arrDef), scans round-robin for a free cell,
//   pulses a one-hot WRITE select to it, then returns the chosen index.
//   Sits between the host command port and the shared cell broadcast bus.
// PARAMETERS
//   NUM_CELLS  8  number of cells on the bus; any value >= 2, need not be power of 2
//   DATA_W     8  width of handle / broadcast data
//   IDX_W      $clog2(NUM_CELLS)  cell index width (localparam, not overridable)
// PORTS
//   clk         in   1          single clock, rising edge
//   rst_n       in   1          asynchronous, active-low reset
//   req_valid   in   1          allocation request
//   req_ready   out  1          request accepted when valid&&ready
//   req_handle  in   DATA_W     handle to allocate
//   cell_free   in   NUM_CELLS  bit i = resultBool of cell i (combinational from cells)
//   op_code     out  2          bus op: 00 NOP, 01 MARK_AVAIL, 10 WRITE
//   op_handle   out  DATA_W     handle broadcast to cells
//   wr_sel      out  NUM_CELLS  one-hot write enable, valid only when op_code==WRITE
//   busy        out  1          high in any state except IDLE
//   rsp_valid   out  1          response available
//   rsp_ready   in   1          response consumed when valid&&ready
//   rsp_ok      out  1          1 = cell allocated, 0 = bank full
//   rsp_idx     out  IDX_W      allocated cell index (0 when rsp_ok=0)
// BEHAVIOUR
//   Reset (async assert, sync-to-clk deassert by the system): state=IDLE, op_code=00,
//     op_handle=0, wr_sel=0, busy=0, rsp_valid=0, rsp_ok=0, rsp_idx=0, req_ready=1,
//     start_ptr=0, avail_q=0. Reset mid-operation aborts: no WRITE issued, no response.
//   FSM: IDLE -> BCAST -> SCAN -> (COMMIT -> RESP) | RESP -> IDLE.
//   IDLE: req_ready=1. On req_valid: latch req_handle into hdl_q, go BCAST.
//   BCAST (1 cycle): op_code=01, op_handle=hdl_q. At the clock edge capture
//     avail_q<=cell_free, ptr<=start_ptr, cnt<=0; go SCAN.
//   SCAN (1 cell/cycle): op_code=00. If avail_q[ptr]: hit_q<=ptr, go COMMIT.
//     Else if cnt==NUM_CELLS-1: go RESP with rsp_ok=0 (bank full).
//     Else ptr<=(ptr==NUM_CELLS-1)?0:ptr+1, cnt<=cnt+1.
//   COMMIT (1 cycle): op_code=10, op_handle=hdl_q, wr_sel=1<<hit_q (exactly one bit).
//     start_ptr<=(hit_q==NUM_CELLS-1)?0:hit_q+1; rsp_ok<=1, rsp_idx<=hit_q; go RESP.
//   RESP: rsp_valid=1, rsp_ok/rsp_idx held stable until rsp_valid&&rsp_ready;
//     then go IDLE (rsp_valid drops next cycle). req_ready=0 until back in IDLE.
//   Latency (accept at cycle t, hit at scan offset k from start_ptr, 0<=k<NUM_CELLS):
//     MARK_AVAIL at t+1, WRITE at t+3+k, rsp_valid at t+4+k. Full bank: rsp_valid at
//     t+2+NUM_CELLS, no WRITE issued.
//   Changes on cell_free outside BCAST are ignored (snapshot semantics).
//   req_valid while busy is not accepted and not lost; requester holds it.
//   Back-to-back: a request valid in the cycle IDLE is re-entered is accepted that cycle.
//   start_ptr persists across requests (round-robin fairness), reset only by rst_n.
//   All outputs registered or decoded from state only; no combinational path from
//   req_valid/rsp_ready/cell_free to any output.
// TESTING
//   1) Reset, cell_free=8'hFF, req handle 8'h2A -> MARK_AVAIL@t+1 hdl 2A, WRITE@t+3
//      wr_sel=8'h01, rsp ok=1 idx=0 @t+4.
//   2) Second request, cell_free=8'hFE -> scan starts at 1, WRITE wr_sel=8'h02 @t+3,
//      idx=1; third with cell_free=8'h81 and start_ptr=2 -> wraps, idx=7 @t+9.
//   3) cell_free=8'h00 -> no WRITE, rsp ok=0 idx=0 at t+10; start_ptr unchanged.
//   4) cell_free toggled to 8'h00 during SCAN after BCAST snapshot 8'h10 -> still
//      allocates idx 4; hold rsp_ready=0 for 5 cycles -> rsp fields stable, req_ready=0.
//   5) Assert rst_n=0 during SCAN -> all outputs to reset values immediately, no
//      WRITE/rsp ever emitted for that request; next request scans from index 0.
//   6) NUM_CELLS=5: cell_free=5'b00001 with start_ptr=3 -> wrap 3,4,0, idx=0, k=2.

Source files
------------

// File: rtl/esfa_alloc_sequencer.sv
// -----------------------------------------------------------------------------
// esfa_alloc_sequencer
//   Allocates a new array handle onto the ESFA cell bank. Each accepted request
//   broadcasts MARK_AVAIL to every cell and snapshots the per-cell free flags.
//   It then scans round-robin, one cell per cycle, from the cell after the last
//   allocation. A one-hot WRITE goes to the first free cell, and the chosen
//   index (or "bank full") is returned on the response port.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req_valid/ready     request handshake, req_handle = handle to allocate
//   cell_free           per-cell free flags, sampled only in the broadcast cycle
//   op_code/op_handle   cell bus: 00 NOP, 01 MARK_AVAIL, 10 WRITE
//   wr_sel              one-hot write select, non-zero only with WRITE
//   busy                high whenever the sequencer is not idle
//   rsp_valid/ready     response handshake, rsp_ok / rsp_idx = result
// -----------------------------------------------------------------------------
module esfa_alloc_sequencer #(
    parameter  int NUM_CELLS = 8,
    parameter  int DATA_W    = 8,
    localparam int IDX_W     = $clog2(NUM_CELLS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [DATA_W-1:0]    req_handle,
    input  logic [NUM_CELLS-1:0] cell_free,
    output logic [1:0]           op_code,
    output logic [DATA_W-1:0]    op_handle,
    output logic [NUM_CELLS-1:0] wr_sel,
    output logic                 busy,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_ok,
    output logic [IDX_W-1:0]     rsp_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CELLS - 1);
    localparam logic [1:0]       OP_NOP    = 2'b00;
    localparam logic [1:0]       OP_MARK   = 2'b01;
    localparam logic [1:0]       OP_WRITE  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BCAST  = 3'd1,
        ST_SCAN   = 3'd2,
        ST_COMMIT = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [DATA_W-1:0]      hdl_q;
    logic [NUM_CELLS-1:0]   avail_q;
    logic [IDX_W-1:0]       ptr_r;
    logic [IDX_W-1:0]       cnt_r;
    logic [IDX_W-1:0]       hit_q;
    logic [IDX_W-1:0]       start_ptr_r;

    logic [1:0]             op_code_r;
    logic [DATA_W-1:0]      op_handle_r;
    logic [NUM_CELLS-1:0]   wr_sel_r;
    logic                   busy_r;
    logic                   rsp_valid_r;
    logic                   rsp_ok_r;
    logic [IDX_W-1:0]       rsp_idx_r;
    logic                   req_ready_r;

    // Cell index successor with wrap; NUM_CELLS need not be a power of two.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        next_idx = (idx == LAST_IDX) ? {IDX_W{1'b0}} : idx + IDX_W'(1);
    endfunction

    // One-hot decode of a cell index.
    function automatic logic [NUM_CELLS-1:0] onehot_sel(input logic [IDX_W-1:0] idx);
        onehot_sel = {{(NUM_CELLS-1){1'b0}}, 1'b1} << idx;
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    state_nxt_s = ST_BCAST;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BCAST:  state_nxt_s = ST_SCAN;
            ST_SCAN: begin
                if (avail_q[ptr_r]) begin
                    state_nxt_s = ST_COMMIT;
                end else if (cnt_r == LAST_IDX) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_SCAN;
                end
            end
            ST_COMMIT: state_nxt_s = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // Datapath: handle latch, free-flag snapshot, scan pointer and result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdl_q       <= {DATA_W{1'b0}};
            avail_q     <= {NUM_CELLS{1'b0}};
            ptr_r       <= {IDX_W{1'b0}};
            cnt_r       <= {IDX_W{1'b0}};
            hit_q       <= {IDX_W{1'b0}};
            start_ptr_r <= {IDX_W{1'b0}};
            rsp_ok_r    <= 1'b0;
            rsp_idx_r   <= {IDX_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        hdl_q <= req_handle;
                    end
                end
                ST_BCAST: begin
                    avail_q <= cell_free;
                    ptr_r   <= start_ptr_r;
                    cnt_r   <= {IDX_W{1'b0}};
                end
                ST_SCAN: begin
                    if (avail_q[ptr_r]) begin
                        hit_q <= ptr_r;
                    end else if (cnt_r == LAST_IDX) begin
                        rsp_ok_r  <= 1'b0;
                        rsp_idx_r <= {IDX_W{1'b0}};
                    end else begin
                        ptr_r <= next_idx(ptr_r);
                        cnt_r <= cnt_r + IDX_W'(1);
                    end
                end
                ST_COMMIT: begin
                    start_ptr_r <= next_idx(hit_q);
                    rsp_ok_r    <= 1'b1;
                    rsp_idx_r   <= hit_q;
                end
                default: begin
                end
            endcase
        end
    end

    // Bus and handshake outputs, registered from the state being entered so
    // they line up with the state and never see a combinational input path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_code_r   <= OP_NOP;
            op_handle_r <= {DATA_W{1'b0}};
            wr_sel_r    <= {NUM_CELLS{1'b0}};
            busy_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
            req_ready_r <= 1'b1;
        end else begin
            busy_r      <= (state_nxt_s != ST_IDLE);
            rsp_valid_r <= (state_nxt_s == ST_RESP);
            req_ready_r <= (state_nxt_s == ST_IDLE);
            if (state_nxt_s == ST_BCAST) begin
                // Entering BCAST only happens from IDLE, where hdl_q is not yet loaded.
                op_code_r   <= OP_MARK;
                op_handle_r <= req_handle;
                wr_sel_r    <= {NUM_CELLS{1'b0}};
            end else if (state_nxt_s == ST_COMMIT) begin
                // COMMIT is entered from SCAN on a hit at ptr_r.
                op_code_r   <= OP_WRITE;
                op_handle_r <= hdl_q;
                wr_sel_r    <= onehot_sel(ptr_r);
            end else begin
                op_code_r   <= OP_NOP;
                op_handle_r <= {DATA_W{1'b0}};
                wr_sel_r    <= {NUM_CELLS{1'b0}};
            end
        end
    end

    assign req_ready = req_ready_r;
    assign op_code   = op_code_r;
    assign op_handle = op_handle_r;
    assign wr_sel    = wr_sel_r;
    assign busy      = busy_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_ok    = rsp_ok_r;
    assign rsp_idx   = rsp_idx_r;

endmodule
